// File: rtl/riscv_exec_pkg.sv
// riscv_exec_pkg: shared constants for the execute/memory/writeback stage
package riscv_exec_pkg;
  localparam int XLEN = 32;
  localparam int EXE_FUN_W = 19;
  localparam int F_ADD = 18;
  localparam int F_SUB = 17;
  localparam int F_AND = 16;
  localparam int F_OR = 15;
  localparam int F_XOR = 14;
  localparam int F_SLL = 13;
  localparam int F_SRL = 12;
  localparam int F_SRA = 11;
  localparam int F_SLT = 10;
  localparam int F_SLTU = 9;
  localparam int F_BEQ = 8;
  localparam int F_BNE = 7;
  localparam int F_BGE = 6;
  localparam int F_BGEU = 5;
  localparam int F_BLT = 4;
  localparam int F_BLTU = 3;
  localparam int F_JALR = 2;
  localparam int F_COPY1 = 1;
  localparam int F_X = 0;
  localparam int WB_CSR = 0;
  localparam int WB_PC = 1;
  localparam int WB_MEM = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU and branch comparator driven by a one-hot function vector
module exec_alu
  import riscv_exec_pkg::*;
#(
  parameter int XLEN = riscv_exec_pkg::XLEN,
  parameter int EXE_FUN_W = riscv_exec_pkg::EXE_FUN_W
) (
  input  logic [XLEN-1:0]      op1_i,
  input  logic [XLEN-1:0]      op2_i,
  input  logic [EXE_FUN_W-1:0] fun_i,
  output logic [XLEN-1:0]      result_o,
  output logic                 cond_o
);
  logic [4:0] sh;
  logic valid, eq, lt, ltu;
  logic [XLEN-1:0] sra_r, sum;
  assign sh = op2_i[4:0];
  // Anything other than exactly one set bit is treated as a no-op.
  assign valid = (fun_i != '0) && ((fun_i & (fun_i - EXE_FUN_W'(1))) == '0);
  assign eq = op1_i == op2_i;
  assign lt = $signed(op1_i) < $signed(op2_i);
  assign ltu = op1_i < op2_i;
  assign sra_r = $signed(op1_i) >>> sh;
  assign sum = op1_i + op2_i;
  always_comb begin
    result_o = !valid          ? '0 :
               fun_i[F_ADD]    ? sum :
               fun_i[F_SUB]    ? op1_i - op2_i :
               fun_i[F_AND]    ? op1_i & op2_i :
               fun_i[F_OR]     ? op1_i | op2_i :
               fun_i[F_XOR]    ? op1_i ^ op2_i :
               fun_i[F_SLL]    ? op1_i << sh :
               fun_i[F_SRL]    ? op1_i >> sh :
               fun_i[F_SRA]    ? sra_r :
               fun_i[F_SLT]    ? {{(XLEN-1){1'b0}}, lt} :
               fun_i[F_SLTU]   ? {{(XLEN-1){1'b0}}, ltu} :
               fun_i[F_JALR]   ? {sum[XLEN-1:1], 1'b0} :
               fun_i[F_COPY1]  ? op1_i : '0;
    cond_o = valid & ((fun_i[F_BEQ] & eq) | (fun_i[F_BNE] & !eq) |
                      (fun_i[F_BGE] & !lt) | (fun_i[F_BGEU] & !ltu) |
                      (fun_i[F_BLT] & lt) | (fun_i[F_BLTU] & ltu) | fun_i[F_JALR]);
  end
endmodule

// File: rtl/exec_mem_wb.sv
// exec_mem_wb: single-issue execute, data-memory access and regfile writeback stage
module exec_mem_wb
  import riscv_exec_pkg::*;
#(
  parameter int XLEN = riscv_exec_pkg::XLEN,
  parameter int EXE_FUN_W = riscv_exec_pkg::EXE_FUN_W,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      op1_data,
  input  logic [XLEN-1:0]      op2_data,
  input  logic [XLEN-1:0]      st_data,
  input  logic [XLEN-1:0]      br_off,
  input  logic [4:0]           rd_in,
  input  logic                 rd_wen_in,
  input  logic [EXE_FUN_W-1:0] exe_fun,
  input  logic                 mem_we,
  input  logic                 mem_re,
  input  logic [2:0]           wb_sel,
  input  logic [XLEN-1:0]      csr_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 br_taken,
  output logic [XLEN-1:0]      br_target,
  output logic [4:0]           wb_addr,
  output logic                 wb_we,
  output logic [XLEN-1:0]      wb_data,
  output logic                 mem_err
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, br_target_q, br_target_d, wb_data_q, wb_data_d;
  logic [4:0] rd_q, rd_d, wb_addr_q, wb_addr_d;
  logic we_q, we_d, ld_wb_q, ld_wb_d, br_taken_q, br_taken_d, wb_we_q, wb_we_d, mem_err_q, mem_err_d;
  logic acc, rd_ok;
  logic [XLEN-1:0] alu_res;
  logic alu_cond;
  exec_alu #(.XLEN(XLEN), .EXE_FUN_W(EXE_FUN_W)) u_alu (
    .op1_i(op1_data),
    .op2_i(op2_data),
    .fun_i(exe_fun),
    .result_o(alu_res),
    .cond_o(alu_cond)
  );
  assign id_ready = state_q == S_IDLE;
  assign acc = id_valid && id_ready;
  assign rd_ok = rd_wen_in && (rd_in != 5'd0);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    rd_d = rd_q;
    ld_wb_d = ld_wb_q;
    br_taken_d = 1'b0;
    br_target_d = br_target_q;
    wb_we_d = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    mem_err_d = 1'b0;
    if (acc && (mem_we || mem_re)) begin
      state_d = S_REQ;
      addr_d = {alu_res[XLEN-1:2], 2'b00};
      wdata_d = st_data;
      we_d = mem_we;
      rd_d = rd_in;
      ld_wb_d = !mem_we && rd_ok;
    end else if (acc) begin
      br_taken_d = alu_cond;
      br_target_d = exe_fun[F_JALR] ? alu_res : pc_in + br_off;
      wb_we_d = rd_ok;
      wb_addr_d = rd_in;
      wb_data_d = wb_sel[WB_CSR] ? csr_rdata : wb_sel[WB_PC] ? pc_in + XLEN'(4) : alu_res;
    end
    if (state_q == S_REQ && dmem_gnt) begin
      state_d = S_WAIT;
      cnt_d = '0;
    end
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (dmem_rvalid) begin
        state_d = S_IDLE;
        wb_we_d = ld_wb_q;
        wb_addr_d = ld_wb_q ? rd_q : wb_addr_q;
        wb_data_d = ld_wb_q ? dmem_rdata : wb_data_q;
      end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
        state_d = S_IDLE;
        mem_err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rd_q <= '0;
      ld_wb_q <= 1'b0;
      br_taken_q <= 1'b0;
      br_target_q <= '0;
      wb_we_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      rd_q <= rd_d;
      ld_wb_q <= ld_wb_d;
      br_taken_q <= br_taken_d;
      br_target_q <= br_target_d;
      wb_we_q <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign dmem_req = state_q == S_REQ;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  assign br_taken = br_taken_q;
  assign br_target = br_target_q;
  assign wb_we = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign mem_err = mem_err_q;
endmodule

// File: doc/exec_mem_wb.md
Name: exec_mem_wb

Overview:
- Consumer end of the decode bundle: op1/op2, rd/rd_wen, one-hot exe_fun, mem_we/mem_re, wb_sel.
- Executes the ALU or branch operation and performs the single-word data-memory access.
- Produces the regfile writeback triple (wb_addr/wb_we/wb_data) that returns to the decoder.
- Single-issue, non-pipelined: one decode bundle in flight at a time, backpressured via id_ready.

Parameters:
- XLEN, 32, datapath width.
- EXE_FUN_W, 19, one-hot function vector width.
- WAIT_MAX, 255, maximum cycles waiting for dmem_rvalid before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  decode bundle valid.
- id_ready  out  1  bundle accepted when id_valid&&id_ready.
- pc_in  in  32  instruction PC.
- op1_data  in  32  ALU operand 1.
- op2_data  in  32  ALU operand 2.
- st_data  in  32  store data (rs2 value).
- br_off  in  32  sign-extended branch offset.
- rd_in  in  5  destination register.
- rd_wen_in  in  1  destination write enable.
- exe_fun  in  19  one-hot; bit18..0 = ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,BEQ,BNE,BGE,BGEU,BLT,BLTU,JALR,COPY1,X.
- mem_we  in  1  store.
- mem_re  in  1  load.
- wb_sel  in  3  one-hot {MEM,PC,CSR}; 000 selects ALU result.
- csr_rdata  in  32  CSR read value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is write.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response valid (loads and stores).
- dmem_rdata  in  32  load data.
- br_taken  out  1  branch/jalr redirect pulse.
- br_target  out  32  redirect PC.
- wb_addr  out  5  writeback register.
- wb_we  out  1  writeback enable pulse.
- wb_data  out  32  writeback value.
- mem_err  out  1  timeout pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- FSM states: IDLE, REQ, WAIT.
- id_ready = (state==IDLE). Inputs are captured into internal registers on handshake; afterwards the inputs are don't-care.
- ALU:
  - SUB is op1-op2.
  - Shifts use op2[4:0]; SRA is arithmetic.
  - SLT is signed, SLTU unsigned; each returns 0/1.
  - COPY1 returns op1.
  - X, zero-hot, or multi-hot exe_fun: result 0, no branch.
  - All arithmetic is mod 2^32.
- Branches: compare op1 vs op2. br_target = pc_in+br_off.
- JALR: always taken; br_target = (op1+op2)&~1.
- br_taken/br_target are registered and pulse for 1 cycle at T+1 for acceptance at T.
- Non-memory op accepted at T:
  - wb_we pulses at T+1 when rd_wen_in && rd_in!=0.
  - wb_data per wb_sel: CSR -> csr_rdata, PC -> pc_in+4, else ALU result.
  - State stays IDLE; back-to-back acceptance is allowed.
- Memory op (mem_re or mem_we) accepted at T:
  - T+1: state REQ, dmem_req=1, dmem_addr = ALU result with [1:0] cleared, dmem_we=mem_we, dmem_wdata=st_data.
  - Request is held stable until dmem_gnt; gnt -> WAIT at the next edge.
  - WAIT: dmem_rvalid -> IDLE. For a load, wb_we pulses the cycle after rvalid with wb_data=dmem_rdata (wb_sel MEM), suppressed if rd_in==0.
  - A store never writes back.
- mem_we && mem_re both set: treated as store, no writeback.
- Timeout: the counter increments each WAIT cycle. When it reaches WAIT_MAX without rvalid -> IDLE, mem_err pulses 1 cycle, no writeback. The counter clears on entering WAIT.
- dmem_rvalid outside WAIT is ignored, including a late response after timeout or reset.
- dmem_gnt outside REQ is ignored.
- Reset mid-operation: immediately IDLE, dmem_req drops asynchronously, any pending writeback is discarded.

Decomposition:
- Package riscv_exec_pkg: exe_fun bit indices, wb_sel indices, FSM state encoding, XLEN.
- Sub-module exec_alu: combinational ALU + branch comparator (op1, op2, exe_fun -> result, cond).
- FSM, capture registers, timeout counter and writeback mux stay in exec_mem_wb.

Test Plan:
- ADD op1=5, op2=0xFFFFFFFE, rd=3 -> wb_we pulse at T+1, wb_addr=3, wb_data=3; id_ready stays 1.
- SRA op1=0x80000000, op2=0x24 -> wb_data=0xF8000000 (shamt 4); SLT(-1,1)=1, SLTU(-1,1)=0.
- BNE op1=1, op2=2, pc=0x100, br_off=-8 -> br_taken pulse, br_target=0xF8; JALR op1=0x201, op2=0 -> target 0x200, wb_data=pc+4 with wb_sel PC.
- Load op1=0x1003, op2=4, rd=7; gnt after 2 cycles, rvalid after 3 more with rdata=0xDEADBEEF -> dmem_addr=0x1004, req held stable, id_ready=0 throughout, wb_we pulse with 0xDEADBEEF one cycle after rvalid.
- Load to rd=0, then store st_data=0x55 -> no wb_we in either case; store shows dmem_we=1, wdata=0x55.
- Load with no rvalid and WAIT_MAX=4 (override) -> mem_err pulse after 4 WAIT cycles, no writeback; a late rvalid is ignored. Separately, rst asserted in REQ -> dmem_req=0 immediately, IDLE, id_ready=1 after release.
